// File: rtl/dmem_responder.sv
// Word-addressed data memory with registered reads and an access trace FIFO.
// One read or write per cycle; every accepted access is queued for the bench.
module dmem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 8,
    parameter     INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr,
    input  logic                           rd,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           err,
    output logic                           trace_valid,
    input  logic                           trace_ready,
    output logic                           trace_is_wr,
    output logic [ADDR_W-1:0]              trace_addr,
    output logic [DATA_W-1:0]              trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);

    localparam int PW    = $clog2(TRACE_DEPTH);
    localparam int CW    = PW + 1;
    localparam int EW    = 1 + ADDR_W + DATA_W;
    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];
    logic [EW-1:0]     tr_mem [TRACE_DEPTH];

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              acc_wr;
    logic              acc_rd;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;
    logic [EW-1:0]     entry;
    logic [EW-1:0]     head;

    // Power-up image: all zero
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
    end

    // Access decode, FIFO control and next-state values
    always_comb begin
        acc_wr     = ~reset & wr & ~rd;
        acc_rd     = ~reset & rd & ~wr;
        push       = acc_wr | acc_rd;
        full       = (count_q == CW'(TRACE_DEPTH));
        pop        = (count_q != '0) & trace_ready;
        do_push    = push & (~full | pop);
        entry      = {acc_wr, addr, acc_wr ? wr_data : mem[addr]};

        rd_data_d  = rd_data_q;
        rd_valid_d = acc_rd;
        err_d      = ~reset & wr & rd;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (acc_rd) rd_data_d = mem[addr];
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !pop) count_d = count_q + CW'(1);
        if (!do_push && pop) count_d = count_q - CW'(1);
        if (push && full && !pop) ovf_d = 1'b1;
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (acc_wr) mem[addr] <= wr_data;
    end

    // Trace storage write port
    always_ff @(posedge clk) begin
        if (do_push) tr_mem[wr_ptr_q] <= entry;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // A read issued just before reset must not show up as valid
    always_comb begin
        head           = tr_mem[rd_ptr_q];
        rd_data        = rd_data_q;
        rd_valid       = rd_valid_q & ~reset;
        err            = err_q;
        trace_valid    = (count_q != '0);
        trace_is_wr    = head[EW-1];
        trace_addr     = head[EW-2 -: ADDR_W];
        trace_data     = head[DATA_W-1:0];
        trace_count    = count_q;
        trace_overflow = ovf_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus multi-cycle sequences.
// Expected values are hand-computed constants.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        trace_valid;
    logic        trace_ready;
    logic        trace_is_wr;
    logic [8:0]  trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_count;
    logic        trace_overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        ready;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_cnt;
    } vec_t;

    vec_t tbl [13];

    dmem_responder #(
        .ADDR_W(9),
        .DATA_W(32),
        .TRACE_DEPTH(8),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr(wr),
        .rd(rd),
        .addr(addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .err(err),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_is_wr(trace_is_wr),
        .trace_addr(trace_addr),
        .trace_data(trace_data),
        .trace_count(trace_count),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [8:0] a,
                         input logic [31:0] d);
        wr      = w;
        rd      = r;
        addr    = a;
        wr_data = d;
    endtask

    task automatic chk_head(input string nm, input logic w,
                            input logic [8:0] a, input logic [31:0] d);
        chk({nm, ".valid"}, 64'(trace_valid), 64'(1));
        chk({nm, ".is_wr"}, 64'(trace_is_wr), 64'(w));
        chk({nm, ".addr"}, 64'(trace_addr), 64'(a));
        chk({nm, ".data"}, 64'(trace_data), 64'(d));
    endtask

    initial begin
        //          wr    rd    addr     wdata         rdy   rv    rd_data       err   cnt
        tbl[0]  = '{1'b0, 1'b1, 9'd5,   32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1};
        tbl[1]  = '{1'b1, 1'b0, 9'd3,   32'h0000_00FF, 1'b1, 1'b0, 32'h0,       1'b0, 1};
        tbl[2]  = '{1'b0, 1'b1, 9'd3,   32'h0,        1'b1, 1'b1, 32'hFF,       1'b0, 1};
        tbl[3]  = '{1'b0, 1'b0, 9'd0,   32'h0,        1'b1, 1'b0, 32'hFF,       1'b0, 0};
        tbl[4]  = '{1'b1, 1'b1, 9'd7,   32'h1234,     1'b1, 1'b0, 32'hFF,       1'b1, 0};
        tbl[5]  = '{1'b0, 1'b1, 9'd7,   32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0, 9'd0,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0};
        tbl[7]  = '{1'b0, 1'b1, 9'd3,   32'h0,        1'b1, 1'b1, 32'hFF,       1'b0, 1};
        tbl[8]  = '{1'b0, 1'b1, 9'd5,   32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0, 9'd0,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0};
        tbl[10] = '{1'b1, 1'b0, 9'd10,  32'h55,       1'b0, 1'b0, 32'h0,        1'b0, 1};
        tbl[11] = '{1'b0, 1'b0, 9'd0,   32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1};
        tbl[12] = '{1'b0, 1'b0, 9'd0,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 0};

        // T1: reset held with a write request present
        reset       = 1'b1;
        trace_ready = 1'b0;
        drive(1'b1, 1'b0, 9'd5, 32'hDEAD);
        cyc();
        cyc();
        chk("t1.rd_data", 64'(rd_data), 64'(0));
        chk("t1.rd_valid", 64'(rd_valid), 64'(0));
        chk("t1.err", 64'(err), 64'(0));
        chk("t1.count", 64'(trace_count), 64'(0));
        chk("t1.tvalid", 64'(trace_valid), 64'(0));
        chk("t1.ovf", 64'(trace_overflow), 64'(0));
        reset = 1'b0;

        // T2/T3 and basic read/write behaviour from the table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
            trace_ready = tbl[i].ready;
            cyc();
            chk($sformatf("v%0d.rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d.rd_data", i), 64'(rd_data), 64'(tbl[i].e_rd));
            chk($sformatf("v%0d.err", i), 64'(err), 64'(tbl[i].e_err));
            chk($sformatf("v%0d.count", i), 64'(trace_count), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d.tvalid", i), 64'(trace_valid),
                64'(tbl[i].e_cnt != 0));
        end

        // T4: trace ordering
        trace_ready = 1'b0;
        drive(1'b1, 1'b0, 9'd1, 32'hA);
        cyc();
        drive(1'b0, 1'b1, 9'd1, 32'h0);
        cyc();
        chk("t4.rd_data", 64'(rd_data), 64'(32'hA));
        drive(1'b1, 1'b0, 9'd511, 32'hB);
        cyc();
        drive(1'b0, 1'b0, 9'd0, 32'h0);
        chk("t4.count", 64'(trace_count), 64'(3));
        trace_ready = 1'b1;
        chk_head("t4.e0", 1'b1, 9'd1, 32'hA);
        cyc();
        chk_head("t4.e1", 1'b0, 9'd1, 32'hA);
        cyc();
        chk_head("t4.e2", 1'b1, 9'd511, 32'hB);
        cyc();
        chk("t4.empty", 64'(trace_valid), 64'(0));
        chk("t4.ovf", 64'(trace_overflow), 64'(0));

        // T5: overflow, then push and pop together while full
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 9'(20 + i), 32'(100 + i));
            cyc();
        end
        drive(1'b0, 1'b0, 9'd0, 32'h0);
        chk("t5.count", 64'(trace_count), 64'(8));
        chk("t5.ovf", 64'(trace_overflow), 64'(1));
        chk_head("t5.head", 1'b1, 9'd20, 32'd100);
        drive(1'b1, 1'b0, 9'd40, 32'h77);
        trace_ready = 1'b1;
        cyc();
        drive(1'b0, 1'b0, 9'd0, 32'h0);
        chk("t5.count_pp", 64'(trace_count), 64'(8));
        chk("t5.ovf_pp", 64'(trace_overflow), 64'(1));
        for (int i = 1; i < 8; i++) begin
            chk_head($sformatf("t5.e%0d", i), 1'b1, 9'(20 + i), 32'(100 + i));
            cyc();
        end
        chk_head("t5.last", 1'b1, 9'd40, 32'h77);
        cyc();
        chk("t5.empty", 64'(trace_valid), 64'(0));
        chk("t5.count0", 64'(trace_count), 64'(0));

        // T6: read followed immediately by reset
        drive(1'b0, 1'b1, 9'd3, 32'h0);
        cyc();
        reset = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 32'h0);
        #1;
        chk("t6.rv_in_reset", 64'(rd_valid), 64'(0));
        cyc();
        chk("t6.rv_after", 64'(rd_valid), 64'(0));
        chk("t6.ovf_clr", 64'(trace_overflow), 64'(0));
        chk("t6.count", 64'(trace_count), 64'(0));
        chk("t6.rd_data", 64'(rd_data), 64'(0));
        reset = 1'b0;
        drive(1'b0, 1'b1, 9'd3, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 9'd0, 32'h0);
        chk("t6.rv", 64'(rd_valid), 64'(1));
        chk("t6.mem3", 64'(rd_data), 64'(32'hFF));
        chk("t6.count1", 64'(trace_count), 64'(1));
        cyc();
        chk("t6.rv_pulse", 64'(rd_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
